cacheline_burst_adaptor: RTL and testbench

Parametrised bridge between a cache's full-line miss/writeback port (dfp) and the burst-oriented backing memory (bmem). A line is split into `LINE_W/BEAT_W` beats on writeback and reassembled from beats on fill. The request address and write data are latched at acceptance, so the cache may change its inputs mid-burst. An optional checker validates returned read addresses. The block sits between each cache (or the cache arbiter) and the memory model.

---
 rtl/cacheline_burst_adaptor.sv | 187 ++++++++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_burst_adaptor
// Description : Bridge between a cache's full-line miss/writeback port (dfp)
//               and a burst-oriented backing memory (bmem). Writebacks are
//               split into LINE_W/BEAT_W beats. Fills are reassembled from
//               beats. The request address and write line are latched when
//               the request is accepted, so the cache may change its inputs
//               mid-burst.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               dfp_addr/read/write  - line request from the cache
//               dfp_wdata            - writeback line (beat k at [k*BEAT_W])
//               dfp_rdata/resp       - fill line and one-cycle completion
//               bmem_addr/read       - line-aligned address, read burst req
//               bmem_write/wdata     - write beat valid and data
//               bmem_ready           - memory accepts request/beat
//               bmem_raddr/rdata/rvalid - returning read beat and its tag
//               err                  - sticky protocol error flag
// Options     : CACHELINE_ADAPTOR_RADDR_CHECK_EN - when defined, each read
//               beat's bmem_raddr is compared with the latched line address,
//               and rvalid outside the data phase also flags err. When
//               undefined err is tied low and bmem_raddr is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_burst_adaptor #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              err
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFS   = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_DATA  = 3'd2,
        S_WR_BURST = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [BEAT_W-1:0] r_wbuf [BEATS];
    logic [BEAT_W-1:0] r_rbuf [BEATS];
    logic              r_bmem_read;
    logic              r_bmem_write;
    logic [BEAT_W-1:0] r_bmem_wdata;
    logic              r_dfp_resp;

    logic [ADDR_W-1:0] w_line_addr;
    logic [CNT_W-1:0]  w_cnt_next;

    assign w_line_addr = {dfp_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
    assign w_cnt_next  = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= '0;
            r_dfp_resp   <= 1'b0;
            for (int k = 0; k < BEATS; k++) begin
                r_wbuf[k] <= '0;
                r_rbuf[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Write has priority; a simultaneous read is dropped.
                    if (dfp_write) begin
                        r_addr <= w_line_addr;
                        for (int k = 0; k < BEATS; k++) begin
                            r_wbuf[k] <= dfp_wdata[k*BEAT_W +: BEAT_W];
                        end
                        r_cnt        <= '0;
                        r_bmem_write <= 1'b1;
                        r_bmem_wdata <= dfp_wdata[BEAT_W-1:0];
                        r_state      <= S_WR_BURST;
                    end else if (dfp_read) begin
                        r_addr      <= w_line_addr;
                        r_cnt       <= '0;
                        r_bmem_read <= 1'b1;
                        r_state     <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (bmem_ready) begin
                        r_bmem_read <= 1'b0;
                        r_state     <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (bmem_rvalid) begin
                        r_rbuf[r_cnt] <= bmem_rdata;
                        r_cnt         <= w_cnt_next;
                        if (r_cnt == c_last) begin
                            r_dfp_resp <= 1'b1;
                            r_state    <= S_RESP;
                        end
                    end
                end
                S_WR_BURST: begin
                    // The next beat is preloaded on acceptance so that
                    // bmem_wdata is a pure register and holds during stalls.
                    if (bmem_ready) begin
                        r_cnt <= w_cnt_next;
                        if (r_cnt == c_last) begin
                            r_bmem_write <= 1'b0;
                            r_dfp_resp   <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_bmem_wdata <= r_wbuf[w_cnt_next];
                        end
                    end
                end
                S_RESP: begin
                    r_dfp_resp <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_pack
        assign dfp_rdata[g*BEAT_W +: BEAT_W] = r_rbuf[g];
    end

    assign dfp_resp   = r_dfp_resp;
    assign bmem_addr  = r_addr;
    assign bmem_read  = r_bmem_read;
    assign bmem_write = r_bmem_write;
    assign bmem_wdata = r_bmem_wdata;

`ifdef CACHELINE_ADAPTOR_RADDR_CHECK_EN
    logic r_err;
    logic w_unused_ofs;

    assign w_unused_ofs = ^dfp_addr[OFS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (bmem_rvalid &&
                     ((r_state != S_RD_DATA) || (bmem_raddr != r_addr))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_inputs;

    assign w_unused_inputs = ^{bmem_raddr, dfp_addr[OFS-1:0]};
    assign err             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adaptor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_burst_adaptor
// Description : Scoreboard bench for cacheline_burst_adaptor. Stimulus pushes
//               expected read requests, write beats and responses into
//               queues; a negedge monitor pops and compares them. Two extra
//               instances cover the 4-beat (128/32) and 8-beat (512/64)
//               configurations with directed read/write sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_burst_adaptor;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;

`ifdef CACHELINE_ADAPTOR_RADDR_CHECK_EN
    localparam logic c_chk = 1'b1;
`else
    localparam logic c_chk = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read, dfp_write;
    logic [LINE_W-1:0] dfp_wdata, dfp_rdata;
    logic              dfp_resp;
    logic [ADDR_W-1:0] bmem_addr, bmem_raddr;
    logic              bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [BEAT_W-1:0] bmem_wdata, bmem_rdata;
    logic              err;

    cacheline_burst_adaptor #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err(err)
    );

    // 4-beat instance: LINE_W=128, BEAT_W=32, OFS=4
    logic [31:0]  p4_addr, p4_baddr, p4_wd, p4_rd;
    logic         p4_read, p4_write, p4_resp, p4_bread, p4_bwrite, p4_rvalid, p4_err;
    logic [127:0] p4_wdata, p4_rdata;

    cacheline_burst_adaptor #(.ADDR_W(32), .LINE_W(128), .BEAT_W(32)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .dfp_addr(p4_addr), .dfp_read(p4_read), .dfp_write(p4_write),
        .dfp_wdata(p4_wdata), .dfp_rdata(p4_rdata), .dfp_resp(p4_resp),
        .bmem_addr(p4_baddr), .bmem_read(p4_bread), .bmem_write(p4_bwrite),
        .bmem_wdata(p4_wd), .bmem_ready(1'b1), .bmem_raddr(p4_baddr),
        .bmem_rdata(p4_rd), .bmem_rvalid(p4_rvalid), .err(p4_err)
    );

    // 8-beat instance: LINE_W=512, BEAT_W=64, OFS=6
    logic [31:0]  p8_addr, p8_baddr;
    logic [63:0]  p8_wd, p8_rd;
    logic         p8_read, p8_write, p8_resp, p8_bread, p8_bwrite, p8_rvalid, p8_err;
    logic [511:0] p8_wdata, p8_rdata;

    cacheline_burst_adaptor #(.ADDR_W(32), .LINE_W(512), .BEAT_W(64)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .dfp_addr(p8_addr), .dfp_read(p8_read), .dfp_write(p8_write),
        .dfp_wdata(p8_wdata), .dfp_rdata(p8_rdata), .dfp_resp(p8_resp),
        .bmem_addr(p8_baddr), .bmem_read(p8_bread), .bmem_write(p8_bwrite),
        .bmem_wdata(p8_wd), .bmem_ready(1'b1), .bmem_raddr(p8_baddr),
        .bmem_rdata(p8_rd), .bmem_rvalid(p8_rvalid), .err(p8_err)
    );

    int checks = 0;
    int errors = 0;
    int n_resp = 0;

    typedef struct {
        bit                is_read;
        logic [LINE_W-1:0] line;
    } resp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [BEAT_W-1:0] data;
    } wbeat_t;

    resp_t             exp_resp  [$];
    logic [ADDR_W-1:0] exp_raddr [$];
    wbeat_t            exp_wbeat [$];

    function automatic void check(input string name, input logic [511:0] act,
                                  input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares every DUT output event with the scoreboard.
    // ------------------------------------------------------------------
    logic              prev_stall = 1'b0;
    logic [BEAT_W-1:0] prev_wdata = '0;

    always @(negedge clk) begin
        if (bmem_read && bmem_ready) begin
            if (exp_raddr.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_bmem_read: addr %0h, none expected", bmem_addr);
            end else begin
                check("bmem_read_addr", bmem_addr, exp_raddr.pop_front());
            end
        end
        if (prev_stall) begin
            check("stall_hold_write", bmem_write, 1'b1);
            check("stall_hold_wdata", bmem_wdata, prev_wdata);
        end
        if (bmem_write && bmem_ready) begin
            if (exp_wbeat.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write_beat: data %0h, none expected", bmem_wdata);
            end else begin
                wbeat_t w;
                w = exp_wbeat.pop_front();
                check("wr_beat_data", bmem_wdata, w.data);
                check("wr_beat_addr", bmem_addr, w.addr);
            end
        end
        prev_stall = bmem_write && !bmem_ready;
        prev_wdata = bmem_wdata;
        if (dfp_resp) begin
            n_resp++;
            if (exp_resp.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_dfp_resp: got resp, none expected");
            end else begin
                resp_t r;
                r = exp_resp.pop_front();
                if (r.is_read) check("dfp_rdata", dfp_rdata, r.line);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks. Each starts 1 ns after a rising edge and ends 1 ns
    // after the rising edge following dfp_resp, with the request dropped.
    // ------------------------------------------------------------------
    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line,
                           input int bad_beat);
        logic [ADDR_W-1:0] al;
        resp_t             r;
        al = {a[ADDR_W-1:5], 5'b0};
        exp_raddr.push_back(al);
        r.is_read = 1'b1;
        r.line    = line;
        exp_resp.push_back(r);
        dfp_addr   = a;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_req_timing", bmem_read, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < BEATS; i++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = line[i*BEAT_W +: BEAT_W];
            bmem_raddr  = (i == bad_beat) ? (al ^ 32'h0000_1000) : al;
            @(posedge clk); #1;
        end
        bmem_rvalid = 1'b0;
        @(negedge clk);
        check("rd_resp_timing", dfp_resp, 1'b1);
        @(posedge clk); #1;
        dfp_read = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line,
                            input logic also_read, input logic [6:0] pat, input int plen,
                            input int exp_lat);
        logic [ADDR_W-1:0] al;
        resp_t             r;
        wbeat_t            w;
        int                lat;
        bit                got;
        al = {a[ADDR_W-1:5], 5'b0};
        for (int i = 0; i < BEATS; i++) begin
            w.addr = al;
            w.data = line[i*BEAT_W +: BEAT_W];
            exp_wbeat.push_back(w);
        end
        r.is_read = 1'b0;
        r.line    = '0;
        exp_resp.push_back(r);
        dfp_addr   = a;
        dfp_write  = 1'b1;
        dfp_read   = also_read;
        dfp_wdata  = line;
        bmem_ready = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            dfp_wdata  = ~line;
            bmem_ready = (i < plen) ? pat[i] : 1'b1;
            lat++;
            @(negedge clk);
            if (dfp_resp) got = 1'b1;
        end
        check("wr_resp_latency", lat, exp_lat);
        @(posedge clk); #1;
        dfp_write  = 1'b0;
        dfp_read   = 1'b0;
        bmem_ready = 1'b1;
        check("wr_beats_all_sent", exp_wbeat.size(), 0);
    endtask

    task automatic p4_test(input logic [31:0] a, input logic [127:0] line);
        logic [127:0] nl;
        nl = ~line;
        p4_addr = a; p4_read = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("p4_rd_req", p4_bread, 1'b1);
        check("p4_rd_addr", p4_baddr, {a[31:4], 4'b0});
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            p4_rvalid = 1'b1; p4_rd = line[i*32 +: 32];
            @(posedge clk); #1;
        end
        p4_rvalid = 1'b0;
        @(negedge clk);
        check("p4_rd_resp", p4_resp, 1'b1);
        check("p4_rdata", p4_rdata, line);
        @(posedge clk); #1;
        p4_read = 1'b0; p4_write = 1'b1; p4_wdata = nl;
        @(posedge clk); #1;
        p4_wdata = line;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("p4_wr_beat", {p4_bwrite, p4_wd}, {1'b1, nl[i*32 +: 32]});
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("p4_wr_resp", {p4_resp, p4_bwrite}, 2'b10);
        @(posedge clk); #1;
        p4_write = 1'b0;
    endtask

    task automatic p8_test(input logic [31:0] a, input logic [511:0] line);
        logic [511:0] nl;
        nl = ~line;
        p8_addr = a; p8_read = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("p8_rd_req", p8_bread, 1'b1);
        check("p8_rd_addr", p8_baddr, {a[31:6], 6'b0});
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            p8_rvalid = 1'b1; p8_rd = line[i*64 +: 64];
            @(posedge clk); #1;
        end
        p8_rvalid = 1'b0;
        @(negedge clk);
        check("p8_rd_resp", p8_resp, 1'b1);
        check("p8_rdata", p8_rdata, line);
        @(posedge clk); #1;
        p8_read = 1'b0; p8_write = 1'b1; p8_wdata = nl;
        @(posedge clk); #1;
        p8_wdata = line;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("p8_wr_beat", {p8_bwrite, p8_wd}, {1'b1, nl[i*64 +: 64]});
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("p8_wr_resp", {p8_resp, p8_bwrite}, 2'b10);
        @(posedge clk); #1;
        p8_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        p4_addr = '0; p4_read = 1'b0; p4_write = 1'b0; p4_wdata = '0; p4_rd = '0; p4_rvalid = 1'b0;
        p8_addr = '0; p8_read = 1'b0; p8_write = 1'b0; p8_wdata = '0; p8_rd = '0; p8_rvalid = 1'b0;

        #3;
        check("rst_outputs", {dfp_resp, bmem_read, bmem_write, err}, 4'b0000);
        check("rst_bmem_addr", bmem_addr, 32'h0);
        check("rst_bmem_wdata", bmem_wdata, 64'h0);
        check("rst_dfp_rdata", dfp_rdata, 256'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait read
        do_read(32'h0000_1234, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, -1);

        // Write with stalls: ready 1,0,0,1,1,0,1 -> resp 8 cycles after request
        do_write(32'h0000_5678, {64'h4444_0004, 64'h3333_0003, 64'h2222_0002, 64'h1111_0001},
                 1'b0, 7'b1011001, 7, 8);

        // Write with ready always high -> resp at T+BEATS+1
        do_write(32'hFFFF_FFFF, {64'hDDDD_DDDD_0000_0003, 64'hCCCC_CCCC_0000_0002,
                                 64'hBBBB_BBBB_0000_0001, 64'hAAAA_AAAA_0000_0000},
                 1'b0, 7'b0, 0, 5);

        // Simultaneous read+write -> write only, then back-to-back read
        do_write(32'h0000_0040, {64'h0F0F_0003, 64'h0F0F_0002, 64'h0F0F_0001, 64'h0F0F_0000},
                 1'b1, 7'b0, 0, 5);
        do_read(32'h0000_0088, {64'h5555_0003, 64'h5555_0002, 64'h5555_0001, 64'h5555_0000}, -1);

        // Reset mid-read after two beats
        exp_raddr.push_back(32'h0000_3300);
        dfp_addr = 32'h0000_3300; dfp_read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD_0000 + 64'(i); bmem_raddr = 32'h0000_3300;
            @(posedge clk); #1;
        end
        bmem_rvalid = 1'b0; dfp_read = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {dfp_resp, bmem_read, bmem_write, err}, 4'b0000);
        check("midrst_bmem_addr", bmem_addr, 32'h0);
        check("midrst_dfp_rdata", dfp_rdata, 256'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(32'h0000_3300, {64'h7777_0003, 64'h7777_0002, 64'h7777_0001, 64'h7777_0000}, -1);
        check("err_clean_reads", err, 1'b0);

        // Address checker: wrong tag on beat 2, then a clean read (sticky)
        do_read(32'h0000_4444, {64'h9999_0003, 64'h9999_0002, 64'h9999_0001, 64'h9999_0000}, 2);
        check("err_after_bad_raddr", err, c_chk);
        do_read(32'h0000_4480, {64'h8888_0003, 64'h8888_0002, 64'h8888_0001, 64'h8888_0000}, -1);
        check("err_sticky", err, c_chk);
        rst_n = 1'b0;
        #2;
        check("err_cleared_by_reset", err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0000; bmem_rdata = 64'h1;
        @(posedge clk); #1;
        bmem_rvalid = 1'b0;
        @(negedge clk);
        check("err_stray_rvalid", err, c_chk);
        check("idle_after_stray", {bmem_read, bmem_write, dfp_resp}, 3'b000);

        // Other parametrisations
        p4_test(32'h0000_123F, {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000});
        p8_test(32'h0000_12FF, {64'hC7, 64'hC6, 64'hC5, 64'hC4, 64'hC3, 64'hC2, 64'hC1, 64'hC0});
        check("param_err", {p4_err, p8_err}, 2'b00);

        @(posedge clk); #1;
        @(negedge clk);
        check("resp_count", n_resp, 8);
        check("scoreboard_empty", exp_resp.size() + exp_raddr.size() + exp_wbeat.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
